recons_write_scheduler: RTL and testbench
=========================================

RECONS_WRITE_SCHEDULER -- requirements
Module: recons_write_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of reconstruction engines; IMG_W, default 256, image width in pixels; IMG_H, default 256, image height in pixels.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that arms a new frame.
REQ-005 req_valid  input  NUM_REQ  per-engine "block ready"; held high until acked.
REQ-006 req_blk_idx  input  NUM_REQ*10  per-engine raster block index, 0..1023.
REQ-007 req_block  input  NUM_REQ*512  per-engine 64 pixels x 8 bits; pixel k occupies bits [8k+7:8k].
REQ-008 req_ack  output  NUM_REQ  one-hot, one-cycle pulse; the block was latched.
REQ-009 mem_we  output  1  frame-buffer write strobe.
REQ-010 mem_addr  output  13  frame-buffer word address; 1 word = 8 pixels.
REQ-011 mem_wdata  output  64  one block row; column c occupies bits [8c+7:8c].
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the last block of the frame is written.
REQ-014 blocks_written  output  11  count of blocks written in the current frame.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARB, WRITE, DONE.
REQ-016 IDLE: start=1 SHALL clear blocks_written and go to ARB; req_valid SHALL be ignored in IDLE.
REQ-017 ARB, no req_valid high: SHALL stay in ARB with req_ack=0.
REQ-018 ARB, one or more req_valid high: SHALL select one requester round-robin and, in that same cycle:
  - pulse its req_ack;
  - latch its req_blk_idx and req_block;
  - go to WRITE.
REQ-019 Round-robin: priority SHALL start at the requester after the last grant; after reset, priority starts at requester 0.
REQ-020 WRITE SHALL last exactly 8 cycles (r=0..7) with mem_we=1 in each cycle.
REQ-021 In WRITE cycle r, mem_wdata SHALL carry latched pixels 8r..8r+7.
REQ-022 Address arithmetic:
  - bcol = idx mod (IMG_W/8); brow = idx div (IMG_W/8);
  - mem_addr = (brow*8 + r)*(IMG_W/8) + bcol;
  - computed in unsigned arithmetic, truncated to 13 bits.
REQ-023 At the end of WRITE cycle r=7, blocks_written SHALL increment by 1.
REQ-024 After WRITE r=7, the FSM SHALL go to DONE if the new count equals IMG_W*IMG_H/64, otherwise to ARB.
REQ-025 DONE SHALL last 1 cycle with frame_done=1, then return to IDLE.
REQ-026 Latency: the first mem_we SHALL be the cycle after req_ack; throughput is one block per 9 cycles under continuous requests.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 A req_valid deasserted before ack SHALL simply not be granted.
REQ-029 Duplicate block indices SHALL be written without check and counted.
REQ-030 mem_we, req_ack and frame_done SHALL be 0 in all cycles other than those specified above.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL enter IDLE and set: req_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, blocks_written=0, round-robin pointer=0.
REQ-032 Reset mid-WRITE SHALL abort the block; no further mem_we until a new start and grant.

Structure
REQ-033 Pixel width (8), block size (8), block pixel count (64), the FSM state encoding and the derived widths SHALL live in a shared package, recons_pkg.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, pointer; output: one-hot grant).

Verification
REQ-035 Single grant: after start, req_valid=4'b0001 with idx=33, pixel k=k.
  - req_ack=0001 in the ARB cycle;
  - mem_addr = 257, 289, 321, ..., 481 over 8 cycles;
  - first word mem_wdata = 64'h0706050403020100.
REQ-036 All four engines held valid after reset: grant order SHALL be 0,1,2,3,0; ack pulses 9 cycles apart.
REQ-037 Full frame: 1024 blocks, idx 0..1023.
  - frame_done pulses once, the cycle after the last mem_we;
  - blocks_written = 1024;
  - busy=0 on the next cycle.
REQ-038 Reset=0 asserted at WRITE r=3: mem_we=0 on the next cycle and all outputs at reset values; req_valid held with no start SHALL produce no ack.
REQ-039 start pulsed during WRITE: no effect, blocks_written unchanged; req_valid=1 while IDLE: no req_ack.
REQ-040 Boundary index 1023: mem_addr = 7967 for r=0 through 8191 for r=7, with no truncation error.

Source files
------------

// File: rtl/recons_pkg.sv
// Shared constants, FSM encoding and address helper for the reconstruction
// write scheduler.
package recons_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned BLK_DIM = 8;
  localparam int unsigned BLK_PIX = BLK_DIM * BLK_DIM;
  localparam int unsigned IDX_W   = 10;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned ROW_W   = $clog2(BLK_DIM);
  localparam int unsigned WORD_W  = PIX_W * BLK_DIM;
  localparam int unsigned BLOCK_W = PIX_W * BLK_PIX;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word address of pixel row r of raster block idx; bcols = blocks per image row.
  function automatic logic [ADDR_W-1:0] blk_row_addr(
    input logic [IDX_W-1:0] idx,
    input logic [ROW_W-1:0] r,
    input int unsigned      bcols
  );
    int unsigned brow, bcol, a;
    bcol = 32'(idx) % bcols;
    brow = 32'(idx) / bcols;
    a    = (brow * BLK_DIM + 32'(r)) * bcols + bcol;
    return ADDR_W'(a);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(pointer) + i) % N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recons_write_scheduler.sv
// Arbitrates finished 8x8 blocks from the reconstruction engines and writes
// each one row per cycle into the raster frame buffer.
module recons_write_scheduler
  import recons_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]   req_blk_idx,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [WORD_W-1:0]          mem_wdata,
  output logic                       busy,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           blocks_written
);

  localparam int          PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCOLS      = IMG_W / BLK_DIM;
  localparam int unsigned FRAME_BLKS = (IMG_W * IMG_H) / BLK_PIX;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLOCK_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   grant;
  logic [PW-1:0]        gidx;
  logic [IDX_W-1:0]     sel_idx;
  logic [BLOCK_W-1:0]   sel_blk;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign sel_idx = req_blk_idx[int'(gidx)*IDX_W +: IDX_W];
  assign sel_blk = req_block[int'(gidx)*BLOCK_W +: BLOCK_W];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      row_q <= row_d;
      idx_q <= idx_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    row_d      = row_q;
    idx_d      = idx_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    req_ack    = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (|req_valid) begin
          req_ack = grant;
          idx_d   = sel_idx;
          blk_d   = sel_blk;
          row_d   = '0;
          ptr_d   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = blk_row_addr(idx_q, row_q, BCOLS);
        mem_wdata = blk_q[int'(row_q)*WORD_W +: WORD_W];
        row_d     = row_q + 1'b1;
        if (row_q == ROW_W'(BLK_DIM - 1)) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CNT_W'(FRAME_BLKS)) ? ST_DONE : ST_ARB;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign blocks_written = cnt_q;

endmodule

// File: tb/tb_recons_write_scheduler.sv
// Scoreboard bench for recons_write_scheduler: expected frame-buffer writes are
// queued when a grant is expected and checked as mem_we fires.
module tb_recons_write_scheduler;
  import recons_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic [N-1:0]         req_valid;
  logic [N*IDX_W-1:0]   req_blk_idx;
  logic [N*BLOCK_W-1:0] req_block;
  logic [N-1:0]         req_ack;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_W-1:0]    mem_wdata;
  logic                 busy, frame_done;
  logic [CNT_W-1:0]     blocks_written;

  recons_write_scheduler #(.NUM_REQ(N), .IMG_W(256), .IMG_H(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .req_valid      (req_valid),
    .req_blk_idx    (req_blk_idx),
    .req_block      (req_block),
    .req_ack        (req_ack),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .frame_done     (frame_done),
    .blocks_written (blocks_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  fd_cnt = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (mem_we === 1'b1) begin
      wr_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [BLOCK_W-1:0] mk_blk(int seed);
    logic [BLOCK_W-1:0] b;
    for (int k = 0; k < 64; k++) b[8*k +: 8] = 8'(seed + k);
    return b;
  endfunction

  function automatic logic [63:0] row_word(int seed, int r);
    logic [63:0] w;
    for (int c = 0; c < 8; c++) w[8*c +: 8] = 8'(seed + 8*r + c);
    return w;
  endfunction

  function automatic logic [12:0] exp_addr(int idx, int r);
    int a;
    a = ((idx / 32) * 8 + r) * 32 + (idx % 32);
    return 13'(a);
  endfunction

  task automatic push_blk(int idx, int seed, int nrows);
    wr_t e;
    for (int r = 0; r < nrows; r++) begin
      e.addr = exp_addr(idx, r);
      e.data = row_word(seed, r);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(int e, int idx, int seed);
    req_blk_idx[e*IDX_W +: IDX_W]   = 10'(idx);
    req_block[e*BLOCK_W +: BLOCK_W] = mk_blk(seed);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    start     = 1'b0;
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ack(input logic [N-1:0] want, input string name, output int cyc);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (req_ack !== '0) break;
    end
    total++;
    if (req_ack !== want) begin
      bad++;
      $display("FAIL %s ack got=%b want=%b", name, req_ack, want);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_writes got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    req_blk_idx = '0;
    req_block   = '0;
    do_reset();
    @(negedge clk);
    total++;
    if ({req_ack, mem_we, busy, frame_done} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {req_ack, mem_we, busy, frame_done});
    end
    total++;
    if (mem_addr !== 13'd0 || mem_wdata !== 64'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%0d data=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (blocks_written !== 11'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", blocks_written);
    end
  endtask

  task automatic test_idle_ignore();
    step();
    for (int e = 0; e < N; e++) set_eng(e, e, e);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (req_ack !== 4'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore got ack=%b busy=%b want ack=0 busy=0", req_ack, busy);
      end
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_single();
    wr_t e;
    int  c;
    do_reset();
    pulse_start();
    set_eng(0, 33, 0);
    req_valid = 4'b0001;
    for (int r = 0; r < 8; r++) begin
      e.addr = 13'(257 + 32*r);
      e.data = (r == 0) ? 64'h0706050403020100 : row_word(0, r);
      exp_q.push_back(e);
    end
    wait_ack(4'b0001, "single", c);
    step();
    req_valid = '0;
    drain("single");
    @(negedge clk);
    total++;
    if (blocks_written !== 11'd1 || busy !== 1'b1 || req_ack !== 4'b0) begin
      bad++;
      $display("FAIL single_after got cnt=%0d busy=%b ack=%b want cnt=1 busy=1 ack=0",
               blocks_written, busy, req_ack);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int c;
    do_reset();
    pulse_start();
    for (int e = 0; e < N; e++) set_eng(e, 100 + e, 16*e + 1);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(4'(1 << order[g]), "rr_order", c);
      push_blk(100 + order[g], 16*order[g] + 1, 8);
      if (g > 0) begin
        total++;
        if (c != 9) begin
          bad++;
          $display("FAIL rr_spacing grant=%0d got=%0d want=9", g, c);
        end
      end
    end
    step();
    req_valid = '0;
    drain("rr");
  endtask

  task automatic test_start_in_write();
    int c;
    do_reset();
    pulse_start();
    set_eng(0, 5, 7);
    req_valid = 4'b0001;
    wait_ack(4'b0001, "start_in_write", c);
    push_blk(5, 7, 8);
    step();
    req_valid = '0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    drain("start_in_write");
    @(negedge clk);
    total++;
    if (blocks_written !== 11'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_in_write got cnt=%0d busy=%b want cnt=1 busy=1", blocks_written, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int c;
    do_reset();
    pulse_start();
    set_eng(1, 7, 50);
    req_valid = 4'b0010;
    wait_ack(4'b0010, "reset_mid", c);
    push_blk(7, 50, 4);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    @(negedge clk);
    total++;
    if ({req_ack, mem_we, busy, frame_done} !== 7'b0 || mem_addr !== 13'd0 ||
        mem_wdata !== 64'd0 || blocks_written !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid got we=%b ack=%b busy=%b addr=%0d cnt=%0d want all 0",
               mem_we, req_ack, busy, mem_addr, blocks_written);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_rows got=%0d want=0 pending", exp_q.size());
      exp_q.delete();
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (req_ack !== 4'b0) begin
        bad++;
        $display("FAIL reset_mid_noack got=%b want=0", req_ack);
      end
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_boundary();
    wr_t e;
    int  c;
    do_reset();
    pulse_start();
    set_eng(2, 1023, 200);
    req_valid = 4'b0100;
    for (int r = 0; r < 8; r++) begin
      e.addr = 13'(7967 + 32*r);
      e.data = row_word(200, r);
      exp_q.push_back(e);
    end
    wait_ack(4'b0100, "boundary", c);
    step();
    req_valid = '0;
    drain("boundary");
  endtask

  task automatic test_full_frame();
    int c;
    int early;
    do_reset();
    fd_cnt = 0;
    pulse_start();
    set_eng(0, 0, 0);
    req_valid = 4'b0001;
    for (int b = 0; b < 1024; b++) begin
      wait_ack(4'b0001, "frame", c);
      push_blk(b, 3*b, 8);
      step();
      if (b < 1023) set_eng(0, b + 1, 3*(b + 1));
      else          req_valid = '0;
    end
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL frame_done_early got=%0d want=0", early);
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b1 || blocks_written !== 11'd1024 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL frame_done got fd=%b cnt=%0d we=%b want fd=1 cnt=1024 we=0",
               frame_done, blocks_written, mem_we);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || fd_cnt != 1 || blocks_written !== 11'd1024) begin
      bad++;
      $display("FAIL frame_end got busy=%b fd=%b pulses=%0d cnt=%0d want busy=0 fd=0 pulses=1 cnt=1024",
               busy, frame_done, fd_cnt, blocks_written);
    end
    drain("frame");
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    req_valid   = '0;
    req_blk_idx = '0;
    req_block   = '0;
    test_reset();
    test_idle_ignore();
    test_single();
    test_round_robin();
    test_start_in_write();
    test_reset_mid_write();
    test_boundary();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
